// File: rtl/sram_rd_streamer_if.sv
// Command, SRAM-port and output-stream signals of the SRAM read streamer.
// The master modport is the streamer; the slave modport is its environment.
interface sram_rd_streamer_if #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 4
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        input  start, base_addr, len, sram_q, out_ready,
        output busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid, out_last
    );

    modport slave (
        output start, base_addr, len, sram_q, out_ready,
        input  busy, done, sram_cen, sram_wen, sram_a, out_data, out_valid, out_last
    );
endinterface

// File: rtl/sram_rd_streamer.sv
// Issues LEN wrapping row reads to a 1-cycle-latency SRAM and streams the rows
// out through a small credit-controlled FIFO with full valid/ready backpressure.
module sram_rd_streamer #(
    parameter int unsigned DW    = 128,
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 2
) (
    input logic                clk,
    input logic                reset_n,
    sram_rd_streamer_if.master io_bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = OW + 1;
    localparam int unsigned RW = AW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e          r_state;
    logic [AW-1:0]   r_addr;
    logic [RW-1:0]   r_rem;
    logic            r_busy;
    logic            r_done;
    logic            r_pend;
    logic            r_pend_last;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0] r_last_mem;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_occ;

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_valid;
    logic [OW-1:0]   w_occ_nxt;
    logic [CW-1:0]   w_used;
    logic [CW-1:0]   w_avail;

    assign w_valid   = (r_occ != '0);
    assign w_push    = r_pend;
    assign w_pop     = w_valid && io_bus.out_ready;
    assign w_occ_nxt = r_occ + OW'(w_push) - OW'(w_pop);

    // A slot being popped this cycle is free again by the time the read lands,
    // which is what sustains one row per cycle with DEPTH=2.
    assign w_used  = CW'(r_occ) + CW'(r_pend);
    assign w_avail = CW'(DEPTH) + CW'(w_pop);
    assign w_issue = (r_state == StRun) && (w_used < w_avail);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_pend      <= w_issue;
            r_pend_last <= w_issue && (r_rem == RW'(1));
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        if (io_bus.len != '0) begin
                            r_addr  <= io_bus.base_addr;
                            r_rem   <= io_bus.len;
                            r_busy  <= 1'b1;
                            r_state <= StRun;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_issue) begin
                        r_addr <= r_addr + AW'(1);
                        r_rem  <= r_rem - RW'(1);
                        if (r_rem == RW'(1)) r_state <= StDrain;
                    end
                end
                StDrain: begin
                    // No issues remain, so an empty next occupancy means the last row is gone.
                    if (w_occ_nxt == '0) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_last_mem <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]      <= io_bus.sram_q;
                r_last_mem[r_wr_ptr] <= r_pend_last;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_occ <= w_occ_nxt;
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.sram_cen  = ~w_issue;
    assign io_bus.sram_wen  = 1'b1;
    assign io_bus.sram_a    = r_addr;
    assign io_bus.out_data  = r_mem[r_rd_ptr];
    assign io_bus.out_valid = w_valid;
    assign io_bus.out_last  = w_valid && r_last_mem[r_rd_ptr];

    assert property (@(posedge clk) disable iff (!reset_n) !(w_push && r_occ == OW'(DEPTH)));
endmodule
